// File: rtl/mouse_click_event.sv
// mouse_click_event: debounces the MouseCtl button levels and classifies each
// accepted press as left single, left double or right. The cursor position is
// clamped to the screen and captured at the moment of acceptance. The result is
// held in a one-entry valid/ready event buffer for main_State_Machine.
module mouse_click_event #(
    parameter int DEBOUNCE   = 100000,
    parameter int DBL_WINDOW = 30000000,
    parameter int XMAX       = 1024,
    parameter int YMAX       = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MouseLeft,
    input  logic        MouseRight,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [11:0] evt_x,
    output logic [11:0] evt_y,
    output logic        evt_drop
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int WW = (DBL_WINDOW > 1) ? $clog2(DBL_WINDOW + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [WW-1:0] WIN_LOAD = WW'(DBL_WINDOW);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);
    localparam logic [WW-1:0] WIN_ZERO = WW'(0);
    localparam logic [11:0]   XLIM     = 12'(XMAX - 1);
    localparam logic [11:0]   YLIM     = 12'(YMAX - 1);

    localparam logic [1:0] TYPE_LSINGLE = 2'd0;
    localparam logic [1:0] TYPE_RIGHT   = 2'd1;
    localparam logic [1:0] TYPE_LDOUBLE = 2'd2;

    localparam logic SEL_LEFT  = 1'b0;
    localparam logic SEL_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          btnL_q, btnR_q;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] win_q, win_d;
    logic          valid_q, valid_d;
    logic [1:0]    type_q, type_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic          drop_q, drop_d;

    logic          accept_s;
    logic          sel_btn_s;
    logic [1:0]    new_type_s;
    logic [11:0]   x_clamp_s;
    logic [11:0]   y_clamp_s;

    assign sel_btn_s = (sel_q == SEL_RIGHT) ? btnR_q : btnL_q;
    assign x_clamp_s = (xpos > XLIM) ? XLIM : xpos;
    assign y_clamp_s = (ypos > YLIM) ? YLIM : ypos;

    assign evt_valid = valid_q;
    assign evt_type  = type_q;
    assign evt_x     = x_q;
    assign evt_y     = y_q;
    assign evt_drop  = drop_q;

    // Debounce FSM: press qualification, hold tracking and release qualification.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (btnL_q) begin
                    state_d = DEB;
                    sel_d   = SEL_LEFT;
                    cnt_d   = CNT_ONE;
                end else if (btnR_q) begin
                    state_d = DEB;
                    sel_d   = SEL_RIGHT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DEB: begin
                if (!sel_btn_s) begin
                    // Released before the debounce period elapsed: glitch.
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    accept_s = 1'b1;
                    state_d  = HELD;
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!btnL_q && !btnR_q) begin
                    state_d = REL;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = HELD;
                end
            end
            REL: begin
                if (btnL_q || btnR_q) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Click classification and double-click window bookkeeping.
    always_comb begin
        new_type_s = TYPE_LSINGLE;
        if (win_q != WIN_ZERO) begin
            win_d = win_q - WIN_ONE;
        end else begin
            win_d = WIN_ZERO;
        end
        if (accept_s) begin
            // Every acceptance updates the window, even one that gets dropped.
            if (sel_q == SEL_RIGHT) begin
                new_type_s = TYPE_RIGHT;
                win_d      = WIN_ZERO;
            end else if (win_q != WIN_ZERO) begin
                new_type_s = TYPE_LDOUBLE;
                win_d      = WIN_ZERO;
            end else begin
                new_type_s = TYPE_LSINGLE;
                win_d      = WIN_LOAD;
            end
        end else begin
            new_type_s = TYPE_LSINGLE;
        end
    end

    // One-entry event buffer: load, hand off, or flag a drop when full.
    always_comb begin
        valid_d = valid_q;
        type_d  = type_q;
        x_d     = x_q;
        y_d     = y_q;
        drop_d  = 1'b0;
        if (accept_s) begin
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                type_d  = new_type_s;
                x_d     = x_clamp_s;
                y_d     = y_clamp_s;
            end else begin
                // Buffer full and not draining: keep the old event stable.
                drop_d = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters, input synchronisers and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            btnL_q  <= 1'b0;
            btnR_q  <= 1'b0;
            state_q <= IDLE;
            sel_q   <= SEL_LEFT;
            cnt_q   <= CNT_ZERO;
            win_q   <= WIN_ZERO;
            valid_q <= 1'b0;
            type_q  <= 2'd0;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            drop_q  <= 1'b0;
        end else begin
            btnL_q  <= MouseLeft;
            btnR_q  <= MouseRight;
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_mouse_click_event.sv
// Scoreboard bench for mouse_click_event with DEBOUNCE=4, DBL_WINDOW=50.
module tb_mouse_click_event;

    logic        clk;
    logic        rst;
    logic        MouseLeft;
    logic        MouseRight;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_type;
    logic [11:0] evt_x;
    logic [11:0] evt_y;
    logic        evt_drop;

    typedef struct packed {
        logic [1:0]  t;
        logic [11:0] x;
        logic [11:0] y;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  valid_cycles = 0;
    int  drop_cycles  = 0;

    mouse_click_event #(
        .DEBOUNCE  (4),
        .DBL_WINDOW(50),
        .XMAX      (1024),
        .YMAX      (768)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MouseLeft (MouseLeft),
        .MouseRight(MouseRight),
        .xpos      (xpos),
        .ypos      (ypos),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_x     (evt_x),
        .evt_y     (evt_y),
        .evt_drop  (evt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops the scoreboard and compares the event.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'd1, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("evt_type", {30'd0, evt_type}, {30'd0, e.t});
                chk("evt_x", {20'd0, evt_x}, {20'd0, e.x});
                chk("evt_y", {20'd0, evt_y}, {20'd0, e.y});
            end
        end
    end

    // Stability monitor and activity counters.
    logic        stall_prev = 1'b0;
    logic [25:0] held_prev  = 26'd0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && evt_valid) begin
                chk("stable_fields", {6'd0, evt_type, evt_x, evt_y}, {6'd0, held_prev});
            end
            stall_prev <= evt_valid && !evt_ready;
            held_prev  <= {evt_type, evt_x, evt_y};
            if (evt_valid) valid_cycles <= valid_cycles + 1;
            if (evt_drop)  drop_cycles  <= drop_cycles + 1;
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Raw buttons high for 'hold' sampling edges at the given cursor position.
    task automatic click(input logic l, input logic r, input int hold,
                         input logic [11:0] x, input logic [11:0] y);
        @(posedge clk);
        #1;
        xpos = x; ypos = y;
        MouseLeft = l; MouseRight = r;
        repeat (hold) @(posedge clk);
        #1;
        MouseLeft = 1'b0; MouseRight = 1'b0;
    endtask

    function automatic ev_t mk(input logic [1:0] t, input logic [11:0] x, input logic [11:0] y);
        ev_t e;
        e.t = t; e.x = x; e.y = y;
        return e;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
        chk({tag, "_type"},  {30'd0, evt_type},  32'd0);
        chk({tag, "_x"},     {20'd0, evt_x},     32'd0);
        chk({tag, "_y"},     {20'd0, evt_y},     32'd0);
        chk({tag, "_drop"},  {31'd0, evt_drop},  32'd0);
    endtask

    initial begin
        int v0;
        int d0;
        bit seen;
        rst = 1'b1; MouseLeft = 1'b0; MouseRight = 1'b0;
        xpos = 12'd0; ypos = 12'd0; evt_ready = 1'b1;
        gap(3);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        gap(3);

        // Single click with latency check.
        exp_q.push_back(mk(2'd0, 12'd100, 12'd200));
        @(posedge clk);
        #1;
        xpos = 12'd100; ypos = 12'd200; MouseLeft = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) chk("lat_edge4_valid", {31'd0, evt_valid}, 32'd0);
            if (k == 5) chk("lat_edge5_valid", {31'd0, evt_valid}, 32'd1);
            if (k == 6) chk("lat_edge6_valid", {31'd0, evt_valid}, 32'd0);
        end
        MouseLeft = 1'b0;
        gap(70);

        // Glitch rejection.
        v0 = valid_cycles;
        click(1'b1, 1'b0, 3, 12'd1, 12'd2);
        gap(3);
        click(1'b1, 1'b0, 2, 12'd1, 12'd2);
        gap(20);
        chk("glitch_no_event", valid_cycles - v0, 32'd0);

        // Double click, then a third click, then two clicks 60 apart.
        exp_q.push_back(mk(2'd0, 12'd100, 12'd100));
        click(1'b1, 1'b0, 6, 12'd100, 12'd100);
        gap(13);
        exp_q.push_back(mk(2'd2, 12'd101, 12'd102));
        click(1'b1, 1'b0, 6, 12'd101, 12'd102);
        gap(13);
        exp_q.push_back(mk(2'd0, 12'd103, 12'd104));
        click(1'b1, 1'b0, 6, 12'd103, 12'd104);
        gap(70);
        exp_q.push_back(mk(2'd0, 12'd300, 12'd400));
        click(1'b1, 1'b0, 6, 12'd300, 12'd400);
        gap(53);
        exp_q.push_back(mk(2'd0, 12'd301, 12'd401));
        click(1'b1, 1'b0, 6, 12'd301, 12'd401);
        gap(70);

        // Right click with clamping.
        exp_q.push_back(mk(2'd1, 12'd1023, 12'd767));
        click(1'b0, 1'b1, 6, 12'd1500, 12'd900);
        gap(20);

        // Both buttons together: left wins, one event only.
        v0 = valid_cycles;
        exp_q.push_back(mk(2'd0, 12'd5, 12'd6));
        click(1'b1, 1'b1, 6, 12'd5, 12'd6);
        gap(70);
        chk("both_one_event", valid_cycles - v0, 32'd1);

        // Backpressure: second acceptance is dropped, first held.
        evt_ready = 1'b0;
        d0 = drop_cycles;
        exp_q.push_back(mk(2'd0, 12'd10, 12'd20));
        click(1'b1, 1'b0, 6, 12'd10, 12'd20);
        gap(12);
        click(1'b0, 1'b1, 6, 12'd30, 12'd40);
        gap(12);
        chk("drop_pulses", drop_cycles - d0, 32'd1);
        chk("bp_valid_held", {31'd0, evt_valid}, 32'd1);
        @(posedge clk);
        #1;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_cleared", {31'd0, evt_valid}, 32'd0);
        gap(20);

        // Reset during DEB; button held through reset release.
        exp_q.push_back(mk(2'd0, 12'd7, 12'd8));
        @(posedge clk);
        #1;
        xpos = 12'd7; ypos = 12'd8; MouseLeft = 1'b1;
        gap(3);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("rst_deb");
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) chk("post_rst_edge4_valid", {31'd0, evt_valid}, 32'd0);
            if (k == 5) chk("post_rst_edge5_valid", {31'd0, evt_valid}, 32'd1);
        end
        gap(2);
        #1;
        MouseLeft = 1'b0;
        gap(20);

        // Reset with an event pending: the event is discarded.
        evt_ready = 1'b0;
        click(1'b1, 1'b0, 6, 12'd50, 12'd60);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (evt_valid) seen = 1'b1;
        end
        chk("pending_seen", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("rst_pending");
        rst = 1'b0;
        evt_ready = 1'b1;
        gap(20);
        #1;
        chk("no_event_after_rst", {31'd0, evt_valid}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mouse_click_event.md
Name: mouse_click_event

Overview:
- Sits between MouseCtl and main_State_Machine in the clk100MHz domain.
- Debounces MouseLeft/MouseRight and classifies each accepted press as left single, left double or right.
- Captures the clamped cursor position at acceptance and presents the result as a one-entry valid/ready event.
- Replaces raw level sampling of the buttons in downstream control logic.

Parameters:
- DEBOUNCE, 100000: cycles a button must be stably high (or released) to count; minimum 2.
- DBL_WINDOW, 30000000: cycles after a left single within which a second left press is a double.
- XMAX, 1024: horizontal resolution; evt_x is clamped to XMAX-1.
- YMAX, 768: vertical resolution; evt_y is clamped to YMAX-1.

Ports:
- clk  in  1  clk100MHz domain clock.
- rst  in  1  synchronous, active-high reset.
- MouseLeft  in  1  raw left button level from MouseCtl.
- MouseRight  in  1  raw right button level from MouseCtl.
- xpos  in  12  cursor x from MouseCtl.
- ypos  in  12  cursor y from MouseCtl.
- evt_valid  out  1  event pending.
- evt_ready  in  1  consumer accepts the event when high together with evt_valid.
- evt_type  out  2  0 = left single, 1 = right, 2 = left double; 3 is never produced.
- evt_x  out  12  clamped x at acceptance.
- evt_y  out  12  clamped y at acceptance.
- evt_drop  out  1  one-cycle pulse when an accepted press is lost because the buffer is full.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: evt_valid, evt_type, evt_x, evt_y, evt_drop all 0. FSM in IDLE. Debounce counter 0. Window counter 0.
- Input stage:
  - MouseLeft/MouseRight are registered once (btnL_q, btnR_q).
  - xpos/ypos are sampled directly at acceptance.
- FSM states: IDLE, DEB, HELD, REL.
- IDLE:
  - btnL_q=1 → DEB with sel=LEFT, cnt=1.
  - Otherwise btnR_q=1 → DEB with sel=RIGHT, cnt=1.
  - Left has priority when both are high.
- DEB:
  - Selected button low → IDLE. Glitch; no event.
  - Otherwise, cnt==DEBOUNCE-1 → accept the press and go to HELD.
  - Otherwise cnt++.
  - The non-selected button is ignored.
- HELD: btnL_q=0 and btnR_q=0 → REL, cnt=1. A press of the other button while in HELD produces no event.
- REL:
  - Either button high → HELD.
  - Otherwise, cnt==DEBOUNCE-1 → IDLE.
  - Otherwise cnt++.
- Acceptance latency: evt_valid rises on the (DEBOUNCE+1)th rising edge after the first edge that samples the raw button high. This is one input register plus DEBOUNCE cycles.
- Classification at acceptance:
  - sel=RIGHT → type 1; window cleared to 0.
  - sel=LEFT with window≠0 → type 2; window cleared to 0.
  - sel=LEFT with window=0 → type 0; window loaded with DBL_WINDOW.
- Window counter decrements by 1 per cycle while nonzero and saturates at 0.
- The window is updated on every acceptance, including dropped ones.
- A triple click yields double, then single.
- Coordinates:
  - evt_x = min(xpos, XMAX-1).
  - evt_y = min(ypos, YMAX-1).
  - Unsigned 12-bit compare.
- Output buffer:
  - Acceptance with evt_valid=0 → load and assert evt_valid.
  - Acceptance with evt_valid=1 and evt_ready=1 in the same cycle → load the new event; evt_valid stays 1; no drop.
  - Acceptance with evt_valid=1 and evt_ready=0 → keep the old event stable; evt_drop=1 for one cycle.
  - evt_valid=1, evt_ready=1, no acceptance → evt_valid=0 next cycle.
  - Fields hold their last values while evt_valid=0.
- Stability: evt_type/evt_x/evt_y must not change while evt_valid=1 and evt_ready=0.
- Reset mid-operation: reset in any state discards any pending event and returns to reset values the next cycle. A button still held after reset must go through DEB again.

Test Plan:
Test parameters: DEBOUNCE=4, DBL_WINDOW=50, evt_ready=1 unless noted.
- Single click: MouseLeft high 10 cycles at xpos=100, ypos=200 → evt_valid high exactly 1 cycle, rising on the 5th edge after press; type 0, x=100, y=200.
- Glitch rejection: MouseLeft high 3 cycles, low, then high 2 cycles → no evt_valid, FSM back to IDLE.
- Double click: two left clicks 20 cycles apart → type 0, then type 2. A third click 20 cycles later → type 0. Clicks 60 cycles apart → type 0, type 0.
- Clamp and right priority:
  - Right click at xpos=1500, ypos=900 → type 1, x=1023, y=767.
  - Left and right rising in the same cycle → one type-0 event only.
- Backpressure: evt_ready=0, left click then right click → first event held unchanged; evt_drop pulses once at the 2nd acceptance. Raising evt_ready → evt_valid drops the next cycle.
- Reset mid-press: assert rst during DEB, and separately with an event pending → all outputs 0 next cycle. Button held through reset release → a new event DEBOUNCE+1 edges later.
